// File: rtl/uart_fifo_core.sv
// UART with register port, 16x-oversampled baud generator and TX/RX FIFOs.
// Optional parity support is compiled in with the UART_PARITY_EN macro.
module uart_fifo_core #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  address,
  input  logic [31:0] write_data,
  input  logic        we,
  input  logic        re,
  output logic [31:0] read_data,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);

`ifdef UART_PARITY_EN
  localparam logic       PARITY_EN = 1'b1;
  localparam logic [6:0] CTRL_MASK = 7'h7f;
`else
  localparam logic       PARITY_EN = 1'b0;
  localparam logic [6:0] CTRL_MASK = 7'h67;
`endif

  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    PTR_ONE  = 1;
  localparam logic [DIV_W-1:0] DIV_ONE = 1;
  localparam logic [3:0]     LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DIV_W-1:0] divisor, baud_cnt;
  logic [6:0]       ctrl;
  logic             overrun, frame_err, parity_err;
  logic             tick, use_parity;
  logic             unused_wd;

  assign unused_wd  = ^write_data;
  assign use_parity = PARITY_EN & ctrl[3];
  assign tick       = (divisor != '0) && (baud_cnt == divisor - DIV_ONE);

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wp, tx_rp, rx_wp, rx_rp;
  logic                 tx_empty, tx_full, rx_empty, rx_full;
  logic                 tx_push, tx_pop, rx_push, rx_pop, rx_done;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);

  state_t               tx_state, rx_state;
  logic [3:0]           tx_sub, tx_bit, rx_sub, rx_bit;
  logic [DATA_BITS-1:0] tx_shift, rx_shift;
  logic                 tx_par, rx_par_bit;
  logic                 rx_meta, rx_sync, rx_prev;
  logic [7:0]           status;

  assign tx_push = we && (address == 2'd2) && !tx_full;
  assign tx_pop  = tick && (tx_state == S_IDLE) && ctrl[0] && !tx_empty;
  assign rx_done = tick && (rx_state == S_STOP) && (rx_sub == 4'd7);
  assign rx_push = rx_done && !rx_full;
  assign rx_pop  = re && (address == 2'd3) && !rx_empty;

  assign status = {tx_state != S_IDLE, parity_err, frame_err, overrun,
                   rx_full, rx_empty, tx_empty, tx_full};
  assign irq = (ctrl[5] & !rx_empty) | (ctrl[6] & tx_empty);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= write_data[DATA_BITS-1:0];
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_shift;
  end

  // Register port, baud counter, FIFO pointers and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor <= '0; baud_cnt <= '0; ctrl <= '0; read_data <= '0;
      tx_wp <= '0; tx_rp <= '0; rx_wp <= '0; rx_rp <= '0;
      overrun <= 1'b0; frame_err <= 1'b0; parity_err <= 1'b0;
    end else begin
      if (we && address == 2'd0)    baud_cnt <= '0;
      else if (divisor == '0 || tick) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + DIV_ONE;
      if (we && address == 2'd0) divisor <= write_data[DIV_W-1:0];
      if (we && address == 2'd1) ctrl <= write_data[6:0] & CTRL_MASK;
      if (tx_push) tx_wp <= tx_wp + PTR_ONE;
      if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
      if (rx_push) rx_wp <= rx_wp + PTR_ONE;
      if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
      if (re) begin
        case (address)
          2'd0:    read_data <= 32'(divisor);
          2'd1:    read_data <= 32'(ctrl);
          2'd2:    read_data <= 32'(status);
          default: read_data <= rx_empty ? 32'd0 : 32'(rx_mem[rx_rp[AW-1:0]]);
        endcase
      end
      // Clear on status read first so a same-cycle event still sets the flag
      if (re && address == 2'd2) begin
        overrun <= 1'b0; frame_err <= 1'b0; parity_err <= 1'b0;
      end
      if (rx_done && rx_full) overrun <= 1'b1;
      if (rx_done && !rx_sync) frame_err <= 1'b1;
      if (rx_done && use_parity && (rx_par_bit != ((^rx_shift) ^ ctrl[4])))
        parity_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= S_IDLE; tx <= 1'b1; tx_sub <= '0; tx_bit <= '0;
      tx_shift <= '0; tx_par <= 1'b0;
    end else if (tick) begin
      if (tx_state == S_IDLE) begin
        if (tx_pop) begin
          tx_state <= S_START;
          tx       <= 1'b0;
          tx_sub   <= '0;
          tx_shift <= tx_mem[tx_rp[AW-1:0]];
          tx_par   <= (^tx_mem[tx_rp[AW-1:0]]) ^ ctrl[4];
        end
      end else begin
        tx_sub <= tx_sub + 4'd1;
        if (tx_sub == 4'd15) begin
          case (tx_state)
            S_START: begin tx_state <= S_DATA; tx <= tx_shift[0]; tx_bit <= '0; end
            S_DATA: begin
              if (tx_bit == LAST_BIT) begin
                tx_bit <= '0;
                if (use_parity) begin tx_state <= S_PARITY; tx <= tx_par; end
                else begin tx_state <= S_STOP; tx <= 1'b1; end
              end else begin
                tx_bit   <= tx_bit + 4'd1;
                tx_shift <= tx_shift >> 1;
                tx       <= tx_shift[1];
              end
            end
            S_PARITY: begin tx_state <= S_STOP; tx <= 1'b1; end
            default: begin
              if (ctrl[2] && tx_bit == 4'd0) tx_bit <= 4'd1;
              else tx_state <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

  // RX: bits sampled on the 8th tick of each 16-tick period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1; rx_sync <= 1'b1; rx_prev <= 1'b1;
      rx_state <= S_IDLE; rx_sub <= '0; rx_bit <= '0;
      rx_shift <= '0; rx_par_bit <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (rx_state == S_IDLE) begin
        if (ctrl[1] && rx_prev && !rx_sync) begin
          rx_state <= S_START;
          rx_sub   <= '0;
        end
      end else if (tick) begin
        rx_sub <= rx_sub + 4'd1;
        case (rx_state)
          S_START: begin
            if (rx_sub == 4'd7 && rx_sync) rx_state <= S_IDLE;
            else if (rx_sub == 4'd15) begin rx_state <= S_DATA; rx_bit <= '0; end
          end
          S_DATA: begin
            if (rx_sub == 4'd7) rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_sub == 4'd15) begin
              if (rx_bit == LAST_BIT) rx_state <= use_parity ? S_PARITY : S_STOP;
              else rx_bit <= rx_bit + 4'd1;
            end
          end
          S_PARITY: begin
            if (rx_sub == 4'd7) rx_par_bit <= rx_sync;
            if (rx_sub == 4'd15) rx_state <= S_STOP;
          end
          default: if (rx_sub == 4'd7) rx_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed testbench for uart_fifo_core: register access, loopback, FIFO limits,
// RX error flags, glitch rejection and asynchronous reset.
module tb_uart_fifo_core;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  address;
  logic [31:0] write_data;
  logic        we, re;
  logic [31:0] read_data;
  logic        tx, irq;
  logic        rx_line, rx_drv, loop_en;
  int          passed = 0;
  int          total  = 0;
  int          fails  = 0;
  int          bitp;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_fifo_core #(.DATA_BITS(8), .FIFO_DEPTH(8), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data),
    .we(we), .re(re), .read_data(read_data), .tx(tx), .rx(rx_line), .irq(irq)
  );

  // 20 MHz clock
  always #25 clk = ~clk;

  initial begin
    #20ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; write_data = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    d = read_data;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    reg_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_tx_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  // Drives one 8-bit frame on rx_drv, optionally with a parity bit, then one idle bit
  task automatic send_frame(input logic [7:0] d, input logic stop_lvl,
                            input bit with_par, input logic par);
    rx_drv = 1'b0;
    repeat (bitp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (bitp) @(negedge clk);
    end
    if (with_par) begin
      rx_drv = par;
      repeat (bitp) @(negedge clk);
    end
    rx_drv = stop_lvl;
    repeat (bitp) @(negedge clk);
    rx_drv = 1'b1;
    repeat (bitp) @(negedge clk);
  endtask

  initial begin
    bit ok;
    int n;
    rst = 1'b1; address = '0; write_data = '0; we = 1'b0; re = 1'b0;
    rx_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_irq", {31'b0, irq}, 32'd0);
    check("reset_read_data", read_data, 32'd0);
    read_check("reset_status", 2'd2, 32'h06);
    read_check("reset_divisor", 2'd0, 32'd0);
    read_check("reset_control", 2'd1, 32'd0);

    // Loopback at divisor 130, 8N1, byte 0x69
    loop_en = 1'b1;
    reg_write(2'd0, 32'd130);
    reg_write(2'd1, 32'h03);
    read_check("divisor_readback", 2'd0, 32'd130);
    reg_write(2'd2, 32'h69);
    wait_tx_low(3000, ok);
    check("loop_start_seen", {31'b0, ok}, 32'd1);
    n = 0;
    while (tx === 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("loop_start_bit_len", n, 32'd2080);
    repeat (20000) @(negedge clk);
    read_check("loop_status", 2'd2, 32'h02);
    reg_write(2'd1, 32'h23);
    check("irq_rx_pending", {31'b0, irq}, 32'd1);
    read_check("loop_data", 2'd3, 32'h69);
    check("irq_after_pop", {31'b0, irq}, 32'd0);
    read_check("loop_status_after", 2'd2, 32'h06);

    // TX FIFO fill with transmitter disabled, then drain through loopback
    bitp = 32;
    reg_write(2'd0, 32'd2);
    reg_write(2'd1, 32'h02);
    for (int i = 1; i <= 8; i++) reg_write(2'd2, 32'(i));
    read_check("tx_full_status", 2'd2, 32'h05);
    reg_write(2'd2, 32'h09);
    reg_write(2'd1, 32'h03);
    repeat (3000) @(negedge clk);
    read_check("tx_drain_status", 2'd2, 32'h0A);
    for (int i = 1; i <= 8; i++) read_check($sformatf("tx_order_%0d", i), 2'd3, 32'(i));
    read_check("tx_drained_empty", 2'd2, 32'h06);

    // RX overrun: nine characters with no reads
    loop_en = 1'b0;
    reg_write(2'd1, 32'h02);
    for (int i = 0; i < 9; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
    read_check("overrun_status", 2'd2, 32'h1A);
    for (int i = 0; i < 8; i++) read_check($sformatf("rx_data_%0d", i), 2'd3, 32'(8'h10 + i));
    read_check("overrun_cleared", 2'd2, 32'h06);
    read_check("rx_empty_read", 2'd3, 32'd0);

    // Frame error: stop bit driven low
    send_frame(8'hB4, 1'b0, 1'b0, 1'b0);
    read_check("frame_err_status", 2'd2, 32'h22);
    read_check("frame_err_data", 2'd3, 32'hB4);
    read_check("frame_err_cleared", 2'd2, 32'h06);

    // Odd parity selected, frame carries even parity bit (0) for 0x55
    reg_write(2'd1, 32'h1A);
`ifdef UART_PARITY_EN
    read_check("parity_control", 2'd1, 32'h1A);
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    read_check("parity_status", 2'd2, 32'h42);
`else
    read_check("parity_control", 2'd1, 32'h02);
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    read_check("parity_status", 2'd2, 32'h22);
`endif
    read_check("parity_data", 2'd3, 32'h55);

    // Two-clock glitch on rx must not produce a character
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * bitp) @(negedge clk);
    read_check("glitch_status", 2'd2, 32'h06);

    // Reset in the middle of a transmitted frame
    reg_write(2'd1, 32'h01);
    reg_write(2'd2, 32'h00);
    wait_tx_low(200, ok);
    check("rst_tx_started", {31'b0, ok}, 32'd1);
    repeat (40) @(negedge clk);
    read_check("busy_status", 2'd2, 32'h86);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async_tx", {31'b0, tx}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_read_data", read_data, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    read_check("rst_status", 2'd2, 32'h06);
    read_check("rst_divisor", 2'd0, 32'd0);
    read_check("rst_control", 2'd1, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_fifo_core.md
# uart_fifo_core

Parametrised UART peripheral with a memory-mapped register port, programmable baud divisor at 16x oversampling, configurable frame format, and TX/RX FIFOs. It is the successor to the single-byte UART top: same bus style (address/we/re), plus buffered transmit and receive, error status and an interrupt line. It sits on the system register bus; `tx`/`rx` go to pads.

## Interface
- `DATA_BITS`, 8 — character length, legal 5..8; data occupies `write_data[DATA_BITS-1:0]`.
- `FIFO_DEPTH`, 8 — entries per FIFO, power of two, 2..64.
- `DIV_W`, 16 — width of the baud divisor register.
- `clk` in 1 — single clock for all logic.
- `rst` in 1 — asynchronous, active-high reset.
- `address` in 2 — register select.
- `write_data` in 32 — write bus.
- `we` in 1 — write strobe; one access per cycle it is high.
- `re` in 1 — read strobe; one access per cycle it is high.
- `read_data` out 32 — registered read bus.
- `tx` out 1 — serial output, idle high.
- `rx` in 1 — serial input, asynchronous to `clk`.
- `irq` out 1 — level interrupt.

## Operation
- Register map, write: 0 = divisor[DIV_W-1:0]; 1 = control; 2 = push TX FIFO; 3 = no effect.
- Register map, read: 0 = divisor; 1 = control; 2 = status; 3 = pop RX FIFO (data in [DATA_BITS-1:0], upper bits 0).
- Control: bit0 tx_en, bit1 rx_en, bit2 two_stop, bit3 parity_en, bit4 parity_odd, bit5 rx_ie, bit6 tx_ie.
- Status: bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full, bit4 overrun, bit5 frame_err, bit6 parity_err, bit7 tx_busy. Bits 4-6 are sticky; reading status clears them. A set event in the same cycle wins over the clear.
- Baud tick: counter counts 0..divisor-1, one-cycle tick at divisor-1. Divisor 0 stops ticks. Bit period = 16 ticks = 16*divisor clocks. A divisor write restarts the counter.
- TX FSM: IDLE -> START -> DATA (LSB first, DATA_BITS bits) -> PARITY (only if enabled) -> STOP (1 or 2 bits) -> IDLE. It leaves IDLE on a tick when tx_en=1 and the TX FIFO is non-empty, popping one entry. tx_busy = state != IDLE.
- Clearing tx_en mid-frame finishes the current frame.
- RX: `rx` goes through a 2-flop synchroniser. RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - A falling edge while rx_en=1 enters START. Tick 8 re-samples; if high, return to IDLE (glitch).
  - Each later bit is sampled at tick 8 of its period. Only one stop bit is checked.
  - At the stop sample: a low stop sets frame_err, a parity mismatch sets parity_err. The character is pushed either way.
  - If the RX FIFO is full, the character is dropped and overrun is set.
- Write to address 2 while TX full: ignored. Read of address 3 while RX empty: returns 0, no pointer change.
- FIFO push and pop in the same cycle: both take effect; count unchanged.
- irq = (rx_ie & !rx_empty) | (tx_ie & tx_empty).
- Reset values: tx=1, read_data=0, irq=0, divisor=0, control=0, both FIFOs empty, sticky flags 0, FSMs IDLE.
- Reset mid-frame aborts immediately; tx returns high asynchronously.

## Timing
- Register writes take effect the cycle after `we`.
- `read_data` is valid the cycle after `re` and holds until the next read.
- The RX pop pointer advances at the `re` edge.
- TX start bit begins on the first tick after the FIFO becomes non-empty with tx_en=1.
- Frame length is (1 + DATA_BITS + parity + stop) * 16 * divisor clocks.
- RX push happens at the stop-bit mid-sample. Sampling latency is 2 synchroniser cycles plus 8 ticks after the edge.
- Simultaneous `we` and `re`: both are performed.

## Configuration
- `UART_PARITY_EN` defined: parity_en/parity_odd are functional. Even parity is used when parity_odd=0. A PARITY state is inserted in both FSMs and parity_err is live.
- Not defined: control bits 3-4 are not stored and read 0. There is no PARITY state, and parity_err always reads 0.

## Test plan
- Loopback (`rx`=`tx`), 20 MHz clk, divisor 130, 8N1, write 0x69 to address 2 -> start bit at ~2080-clock bit period; RX status rx_empty=0; read address 3 returns 0x69.
- Push 9 bytes 0x01..0x09 with FIFO_DEPTH 8, tx_en=0 -> tx_full after 8, 9th dropped; enable -> exactly 0x01..0x08 transmitted in order.
- Receive 9 characters without reading -> rx_full set, overrun=1, first 8 read back intact; second status read shows overrun=0.
- Drive frame 0xB4 with stop bit low -> frame_err=1, 0xB4 still in RX FIFO.
- With `UART_PARITY_EN`, parity_odd=1, inject even-parity frame of 0x55 -> parity_err=1. Without the macro, same frame length check gives parity_err=0.
- Assert `rst` mid-transmit -> tx=1 within same cycle, all status reset values; 2-clock glitch low on `rx` -> no character pushed.
